// File: rtl/fdre_ce_arbiter.sv
// fdre_ce_arbiter
//   Round-robin write arbiter in front of an external bank of FDRE-style flops.
//   It picks one requester, captures that requester's data into reg_d, pulses
//   reg_ce for one cycle, and then returns a one-cycle ack. A locked requester
//   may keep the grant for up to BURST_MAX back-to-back writes. A clear request
//   pulses reg_r and wins over writes whenever the arbiter is idle.
//
// Parameters
//   NREQ      number of requesters (1..8)
//   WIDTH     width of the register bank
//   BURST_MAX maximum consecutive writes for one locked requester
//
// Ports
//   C         clock, rising edge
//   R_N       synchronous active-low reset
//   req       per-requester write request, level, held until ack
//   req_data  write data, requester i at [i*WIDTH +: WIDTH]
//   lock      per-requester burst lock
//   clr_req   clear request, level, held until clr_ack
//   reg_ce    bank clock-enable (one cycle per write)
//   reg_d     bank data, holds its last value outside writes
//   reg_r     bank synchronous clear (one cycle per clear)
//   gnt       one-hot current grant, 0 when idle
//   ack       one-cycle pulse per committed write
//   clr_ack   one-cycle pulse per committed clear
//   busy      high whenever the arbiter is not idle
module fdre_ce_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int BURST_MAX = 4
) (
   input  logic                  C,
   input  logic                  R_N,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]       lock,
   input  logic                  clr_req,
   output logic                  reg_ce,
   output logic [WIDTH-1:0]      reg_d,
   output logic                  reg_r,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic                  clr_ack,
   output logic                  busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ACK, S_CLEAR} state_t;

   state_t                      state;
   logic [PW-1:0]               ptr;    // last requester served
   logic [PW-1:0]               win;    // requester owning the current grant
   logic [BW-1:0]               burst;  // writes issued in the current grant
   logic [NREQ-1:0][WIDTH-1:0]  lane_d;

   // Same bit layout as the flat bus: lane_d[i] is req_data[i*WIDTH +: WIDTH].
   assign lane_d = req_data;

   // Round-robin pick: first requester at or after ptr+1, wrapping modulo NREQ.
   logic [PW-1:0] pick;
   logic          pick_vld;
   always_comb begin
      int            idx;
      logic [PW-1:0] cand;
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      cand     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx  = (int'(ptr) + k) % NREQ;
         cand = PW'(idx);
         if (!pick_vld && req[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // A burst continues only while the owner still asks for it, no clear is
   // pending, and the burst budget is not spent.
   logic cont;
   assign cont = lock[win] & req[win] & ~clr_req & (burst < BW'(BURST_MAX));

   always_ff @(posedge C) begin
      if (!R_N) begin
         state   <= S_IDLE;
         gnt     <= '0;
         ack     <= '0;
         clr_ack <= 1'b0;
         reg_ce  <= 1'b0;
         reg_r   <= 1'b0;
         reg_d   <= '0;
         busy    <= 1'b0;
         ptr     <= PW'(NREQ - 1);
         win     <= '0;
         burst   <= '0;
      end else begin
         // single-cycle pulses default low
         ack     <= '0;
         clr_ack <= 1'b0;
         reg_ce  <= 1'b0;
         reg_r   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clr_req) begin
                  state   <= S_CLEAR;
                  reg_r   <= 1'b1;
                  clr_ack <= 1'b1;
                  gnt     <= '0;
                  busy    <= 1'b1;
               end else if (pick_vld) begin
                  state  <= S_WRITE;
                  win    <= pick;
                  gnt    <= ONE << pick;
                  reg_d  <= lane_d[pick];
                  burst  <= BW'(1);
                  reg_ce <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            S_WRITE: begin
               // bank loads on this edge; acknowledge during the following cycle
               state <= S_ACK;
               ack   <= gnt;
               ptr   <= win;
            end
            S_ACK: begin
               if (cont) begin
                  state  <= S_WRITE;
                  reg_d  <= lane_d[win];
                  burst  <= burst + BW'(1);
                  reg_ce <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  gnt   <= '0;
                  busy  <= 1'b0;
               end
            end
            S_CLEAR: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fdre_ce_arbiter.sv
// Testbench for fdre_ce_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-timeline
// model. An FDRE bank model is driven from the DUT's reg_ce/reg_r/reg_d.
module tb_fdre_ce_arbiter;
   localparam int NREQ      = 4;
   localparam int WIDTH     = 8;
   localparam int BURST_MAX = 4;

   logic                  C = 1'b0;
   logic                  R_N = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ-1:0]       lock = '0;
   logic                  clr_req = 1'b0;
   logic [WIDTH-1:0]      dat [NREQ];
   logic [NREQ*WIDTH-1:0] req_data;
   logic                  reg_ce, reg_r, clr_ack, busy;
   logic [WIDTH-1:0]      reg_d;
   logic [NREQ-1:0]       gnt, ack;

   always #5 C = ~C;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dat[i];
   end

   fdre_ce_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
      .C(C), .R_N(R_N), .req(req), .req_data(req_data), .lock(lock),
      .clr_req(clr_req), .reg_ce(reg_ce), .reg_d(reg_d), .reg_r(reg_r),
      .gnt(gnt), .ack(ack), .clr_ack(clr_ack), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each cycle is described by the outputs it must show. A granted write
   // schedules two cycles (load, then acknowledge); a clear is one cycle.
   typedef struct packed {
      logic             ce;
      logic             r;
      logic             ca;
      logic             busy;
      logic [NREQ-1:0]  gnt;
      logic [NREQ-1:0]  ack;
      logic [WIDTH-1:0] d;
   } exp_t;

   exp_t       cur;
   exp_t       plan [$];
   int         ptr_m, owner, nburst;
   logic [WIDTH-1:0] bank_q;
   logic       s_ce, s_r;
   logic [WIDTH-1:0] s_d;

   function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic issue(input int w);
      exp_t nx;
      nx      = '0;
      owner   = w;
      ptr_m   = w;
      nx.ce   = 1'b1;
      nx.busy = 1'b1;
      nx.gnt  = NREQ'(1) << w;
      nx.d    = req_data[w*WIDTH +: WIDTH];
      cur     = nx;
      nx.ce   = 1'b0;
      nx.ack  = nx.gnt;
      plan.push_back(nx);
   endtask

   task automatic model_step();
      exp_t nx;
      int   w;
      if (!R_N) begin
         plan.delete();
         cur   = '0;
         ptr_m = NREQ - 1;
         return;
      end
      if (plan.size() > 0) begin
         cur = plan.pop_front();
         return;
      end
      nx   = '0;
      nx.d = cur.d;
      if (cur.ack != 0) begin
         // just acknowledged: only the same owner may follow immediately
         if (lock[owner] && req[owner] && !clr_req && nburst < BURST_MAX) begin
            nburst++;
            issue(owner);
            return;
         end
      end else if (!cur.busy) begin
         if (clr_req) begin
            nx.r = 1'b1; nx.ca = 1'b1; nx.busy = 1'b1;
            cur = nx;
            return;
         end
         w = rr_pick(ptr_m, req);
         if (w >= 0) begin
            nburst = 1;
            issue(w);
            return;
         end
      end
      cur = nx;
   endtask

   task automatic compare_cycle();
      chk("reg_ce",  reg_ce,  cur.ce);
      chk("reg_r",   reg_r,   cur.r);
      chk("clr_ack", clr_ack, cur.ca);
      chk("busy",    busy,    cur.busy);
      chk("gnt",     gnt,     cur.gnt);
      chk("ack",     ack,     cur.ack);
      chk("reg_d",   reg_d,   cur.d);
      if (cur.ack != 0) chk("bank_q_on_ack", bank_q, cur.d);
   endtask

   initial begin
      cur = '0; ptr_m = NREQ - 1; owner = 0; nburst = 0;
      bank_q = '0; s_ce = 1'b0; s_r = 1'b0; s_d = '0;
      forever begin
         @(posedge C);
         if (s_r) bank_q = '0;
         else if (s_ce) bank_q = s_d;
         model_step();
         @(negedge C);
         s_ce = reg_ce; s_r = reg_r; s_d = reg_d;
         compare_cycle();
      end
   end

   // ---------------- stimulus ----------------
   logic [NREQ-1:0] exp_g [5];
   int              ack_cnt [NREQ];

   initial begin
      for (int i = 0; i < NREQ; i++) dat[i] = '0;
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

      // reset held with inputs toggling
      repeat (2) begin
         @(negedge C);
         req = NREQ'($urandom); lock = NREQ'($urandom); clr_req = 1'($urandom);
         for (int i = 0; i < NREQ; i++) dat[i] = WIDTH'($urandom);
      end
      @(negedge C);
      chk("rst_ce", reg_ce, 0); chk("rst_r", reg_r, 0); chk("rst_gnt", gnt, 0);
      chk("rst_ack", ack, 0); chk("rst_clr_ack", clr_ack, 0);
      chk("rst_busy", busy, 0); chk("rst_d", reg_d, 0);
      req = '0; lock = '0; clr_req = 1'b0; R_N = 1'b1;

      // single write
      @(negedge C); dat[2] = 8'hA5; req = 4'b0100;
      @(negedge C);
      chk("sw_ce", reg_ce, 1); chk("sw_d", reg_d, 8'hA5); chk("sw_gnt", gnt, 4'b0100);
      @(negedge C);
      chk("sw_ack", ack, 4'b0100); chk("sw_q", bank_q, 8'hA5); req = '0;
      @(negedge C);
      chk("sw_idle_busy", busy, 0); chk("sw_idle_gnt", gnt, 0);

      // fairness, starting from a fresh pointer
      R_N = 1'b0;
      @(negedge C);
      R_N = 1'b1; req = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin dat[i] = WIDTH'(8'h10 + i); ack_cnt[i] = 0; end
      for (int c = 1; c <= 13; c++) begin
         @(negedge C);
         if (c % 3 == 1) chk("fair_gnt", gnt, exp_g[(c - 1) / 3]);
         if (c <= 12) for (int i = 0; i < NREQ; i++) ack_cnt[i] += int'(ack[i]);
      end
      req = '0;
      for (int i = 0; i < NREQ; i++) chk("fair_ack_count", ack_cnt[i], 1);
      repeat (2) @(negedge C);

      // clear has priority over a simultaneous write
      clr_req = 1'b1; req = 4'b0010; dat[1] = 8'h3C;
      @(negedge C);
      chk("clr_r", reg_r, 1); chk("clr_ack", clr_ack, 1);
      chk("clr_ce", reg_ce, 0); chk("clr_gnt", gnt, 0);
      clr_req = 1'b0;
      @(negedge C);
      chk("clr_idle", busy, 0); chk("clr_q", bank_q, 0);
      @(negedge C);
      chk("clr_wr_ce", reg_ce, 1); chk("clr_wr_gnt", gnt, 4'b0010); chk("clr_wr_d", reg_d, 8'h3C);
      @(negedge C);
      chk("clr_wr_ack", ack, 4'b0010); chk("clr_wr_q", bank_q, 8'h3C); req = '0;
      repeat (2) @(negedge C);

      // locked burst limited to BURST_MAX, then requester 0
      lock = 4'b1000; req = 4'b1000; dat[3] = 8'h11;
      for (int c = 1; c <= 8; c++) begin
         @(negedge C);
         if (c % 2 == 1) begin
            chk("burst_ce", reg_ce, 1); chk("burst_gnt", gnt, 4'b1000);
         end else begin
            chk("burst_ack", ack, 4'b1000);
         end
         if (c == 1) begin req[0] = 1'b1; dat[0] = 8'h77; end
         if (c == 2) dat[3] = 8'h22;
         if (c == 3) chk("burst_recapture", reg_d, 8'h22);
      end
      @(negedge C);
      chk("burst_end_gnt", gnt, 0); chk("burst_end_busy", busy, 0);
      req[3] = 1'b0; lock = '0;
      @(negedge C);
      chk("burst_next_gnt", gnt, 4'b0001); chk("burst_next_d", reg_d, 8'h77);
      @(negedge C);
      chk("burst_next_ack", ack, 4'b0001); req = '0;
      @(negedge C);

      // reset mid-write: aborted write not acked, pointer restarts
      req = 4'b0010; dat[1] = 8'h5A;
      @(negedge C);
      chk("mid_pre_gnt", gnt, 4'b0010);
      @(negedge C);
      req = '0;
      @(negedge C);
      req = 4'b0110; dat[2] = 8'hC3;
      @(negedge C);
      chk("mid_gnt", gnt, 4'b0100); chk("mid_ce", reg_ce, 1);
      R_N = 1'b0;
      @(negedge C);
      chk("mid_rst_ack", ack, 0); chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_ce", reg_ce, 0); chk("mid_rst_busy", busy, 0);
      R_N = 1'b1;
      @(negedge C);
      chk("mid_regrant", gnt, 4'b0010); chk("mid_regrant_d", reg_d, 8'h5A);
      @(negedge C);
      chk("mid_regrant_ack", ack, 4'b0010); req = '0;
      repeat (2) @(negedge C);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         @(negedge C);
         R_N = ($urandom_range(0, 199) != 0);
         if (clr_req && clr_ack) clr_req = 1'b0;
         else if (!clr_req && $urandom_range(0, 39) == 0) clr_req = 1'b1;
         if ($urandom_range(0, 15) == 0) lock = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && ack[i]) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               dat[i] = WIDTH'($urandom);
            end else if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req[i] = 1'b1;
                  dat[i] = WIDTH'($urandom);
               end
            end else if ($urandom_range(0, 49) == 0) begin
               req[i] = 1'b0;
            end
         end
      end

      @(negedge C);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
